// File: rtl/core_buf_exchange_pkg.sv
// Shared constants and state encoding for the multicore buffer-exchange hub.
// BUF_W and IDX_W are also used by the processor top's buffer ports.
package core_buf_exchange_pkg;

  localparam int BUF_W = 32;
  localparam int IDX_W = 5;

  typedef enum logic {
    COLLECT = 1'b0,
    READY   = 1'b1
  } state_e;

endpackage

// File: rtl/core_buf_exchange_buf_bank_entry.sv
// One core's bank slot: a pair of captured words plus a valid bit.
// Only the first capture after a clear is kept; clear drops valid but keeps the data.
module core_buf_exchange_buf_bank_entry
  import core_buf_exchange_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic             cap_en,
  input  logic             clr,
  input  logic [BUF_W-1:0] val_1_in,
  input  logic [BUF_W-1:0] val_2_in,
  output logic [BUF_W-1:0] word_1,
  output logic [BUF_W-1:0] word_2,
  output logic             valid
);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      word_1 <= '0;
      word_2 <= '0;
      valid  <= 1'b0;
    end else if (clr) begin
      valid <= 1'b0;
    end else if (cap_en && !valid) begin
      word_1 <= val_1_in;
      word_2 <= val_2_in;
      valid  <= 1'b1;
    end
  end

endmodule

// File: rtl/core_buf_exchange.sv
// Multicore barrier and data-exchange hub: captures each core's word pair, raises
// all_buf_flags once every core has published, and serves bank reads per core.
module core_buf_exchange
  import core_buf_exchange_pkg::*;
#(
  parameter int NCORES  = 4,
  parameter int EPOCH_W = 8
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [NCORES*BUF_W-1:0] buf_val_1_in,
  input  logic [NCORES*BUF_W-1:0] buf_val_2_in,
  input  logic [NCORES-1:0]       buf_flag_in,
  input  logic [NCORES*IDX_W-1:0] buf_val_1_addr,
  input  logic [NCORES*IDX_W-1:0] buf_val_2_addr,
  output logic [NCORES*BUF_W-1:0] buf_val_1_select,
  output logic [NCORES*BUF_W-1:0] buf_val_2_select,
  output logic                    all_buf_flags,
  output logic [EPOCH_W-1:0]      epoch
);

  state_e             state_q, state_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic               clr;
  logic [NCORES-1:0]  valid;
  logic [NCORES-1:0]  capture_mask;
  logic [BUF_W-1:0]   bank1 [NCORES];
  logic [BUF_W-1:0]   bank2 [NCORES];

  // The bank is frozen while READY, so captures are only offered in COLLECT.
  assign capture_mask = (state_q == COLLECT) ? (buf_flag_in & ~valid) : '0;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= COLLECT;
      epoch_q <= '0;
    end else begin
      state_q <= state_d;
      epoch_q <= epoch_d;
    end
  end

  always_comb begin
    state_d = state_q;
    epoch_d = epoch_q;
    clr     = 1'b0;
    case (state_q)
      COLLECT: begin
        if (&(valid | capture_mask)) state_d = READY;
      end
      READY: begin
        // Only an all-low flag vector releases the barrier.
        if (buf_flag_in == '0) begin
          state_d = COLLECT;
          clr     = 1'b1;
          epoch_d = epoch_q + EPOCH_W'(1);
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  for (genvar g = 0; g < NCORES; g++) begin : g_bank
    core_buf_exchange_buf_bank_entry u_entry (
      .Clk      (Clk),
      .Reset    (Reset),
      .cap_en   (capture_mask[g]),
      .clr      (clr),
      .val_1_in (buf_val_1_in[g*BUF_W +: BUF_W]),
      .val_2_in (buf_val_2_in[g*BUF_W +: BUF_W]),
      .word_1   (bank1[g]),
      .word_2   (bank2[g]),
      .valid    (valid[g])
    );
  end

  // Out-of-range indices match no entry and therefore read as zero.
  always_comb begin
    buf_val_1_select = '0;
    buf_val_2_select = '0;
    for (int i = 0; i < NCORES; i++) begin
      for (int j = 0; j < NCORES; j++) begin
        if (buf_val_1_addr[i*IDX_W +: IDX_W] == IDX_W'(j))
          buf_val_1_select[i*BUF_W +: BUF_W] = bank1[j];
        if (buf_val_2_addr[i*IDX_W +: IDX_W] == IDX_W'(j))
          buf_val_2_select[i*BUF_W +: BUF_W] = bank2[j];
      end
    end
  end

  assign all_buf_flags = (state_q == READY);
  assign epoch         = epoch_q;

endmodule

// File: tb/tb_core_buf_exchange.sv
// Bench for core_buf_exchange: directed barrier scenarios plus random traffic,
// checked every cycle against a behavioural model of the barrier and bank.
module tb_core_buf_exchange;

  localparam int NC = 4;
  localparam int EW = 8;

  logic            Clk;
  logic            Reset;
  logic [NC*32-1:0] buf_val_1_in, buf_val_2_in;
  logic [NC-1:0]    buf_flag_in;
  logic [NC*5-1:0]  buf_val_1_addr, buf_val_2_addr;
  logic [NC*32-1:0] buf_val_1_select, buf_val_2_select;
  logic             all_buf_flags;
  logic [EW-1:0]    epoch;

  core_buf_exchange #(.NCORES(NC), .EPOCH_W(EW)) dut (
    .Clk              (Clk),
    .Reset            (Reset),
    .buf_val_1_in     (buf_val_1_in),
    .buf_val_2_in     (buf_val_2_in),
    .buf_flag_in      (buf_flag_in),
    .buf_val_1_addr   (buf_val_1_addr),
    .buf_val_2_addr   (buf_val_2_addr),
    .buf_val_1_select (buf_val_1_select),
    .buf_val_2_select (buf_val_2_select),
    .all_buf_flags    (all_buf_flags),
    .epoch            (epoch)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one entry per core, a barrier-complete flag and a counter.
  logic [31:0] m_b1 [NC];
  logic [31:0] m_b2 [NC];
  bit          m_v  [NC];
  bit          m_ready;
  logic [EW-1:0] m_epoch;

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < NC; i++) begin
        m_b1[i] = '0; m_b2[i] = '0; m_v[i] = 0;
      end
      m_ready = 0;
      m_epoch = '0;
    end else if (!m_ready) begin
      int n;
      n = 0;
      for (int i = 0; i < NC; i++) begin
        if (buf_flag_in[i] && !m_v[i]) begin
          m_b1[i] = buf_val_1_in[i*32 +: 32];
          m_b2[i] = buf_val_2_in[i*32 +: 32];
          m_v[i]  = 1;
        end
        if (m_v[i]) n++;
      end
      if (n == NC) m_ready = 1;
    end else if (buf_flag_in == '0) begin
      m_ready = 0;
      for (int i = 0; i < NC; i++) m_v[i] = 0;
      m_epoch = m_epoch + 1'b1;
    end
  end

  function automatic logic [31:0] exp_sel(input bit second, input logic [4:0] a);
    if (a >= NC) return 32'h0;
    return second ? m_b2[a[1:0]] : m_b1[a[1:0]];
  endfunction

  always @(negedge Clk) begin
    chk("all_buf_flags", {31'b0, all_buf_flags}, {31'b0, m_ready});
    chk("epoch", {24'b0, epoch}, {24'b0, m_epoch});
    for (int i = 0; i < NC; i++) begin
      chk($sformatf("sel1[%0d]", i), buf_val_1_select[i*32 +: 32],
          exp_sel(0, buf_val_1_addr[i*5 +: 5]));
      chk($sformatf("sel2[%0d]", i), buf_val_2_select[i*32 +: 32],
          exp_sel(1, buf_val_2_addr[i*5 +: 5]));
    end
  end

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  int pub [NC] = '{2, 5, 5, 9};

  initial begin
    Reset = 1'b0;
    buf_flag_in = '0;
    buf_val_1_in = '0;
    buf_val_2_in = '0;
    buf_val_1_addr = '0;
    buf_val_2_addr = '0;
    tick();
    tick();
    Reset = 1'b1;
    #1;
    chk("reset_afb", {31'b0, all_buf_flags}, 32'h0);
    chk("reset_epoch", {24'b0, epoch}, 32'h0);

    // Staggered publishing; core 1 changes its word after it was captured.
    for (int c = 0; c <= 9; c++) begin
      for (int i = 0; i < NC; i++) begin
        buf_flag_in[i] = (c >= pub[i]);
        buf_val_1_in[i*32 +: 32] = 32'((i + 1) * 16 + 1);
        buf_val_2_in[i*32 +: 32] = 32'((i + 1) * 16 + 2);
      end
      if (c >= 7) buf_val_1_in[32 +: 32] = 32'hDEAD;
      if (c == 9) chk("afb_before_last", {31'b0, all_buf_flags}, 32'h0);
      tick();
    end
    chk("afb_after_edge9", {31'b0, all_buf_flags}, 32'h1);
    buf_val_1_addr[0 +: 5]  = 5'd3;
    buf_val_2_addr[15 +: 5] = 5'd0;
    buf_val_1_addr[5 +: 5]  = 5'd1;
    #1;
    chk("core0_addr3_w1", buf_val_1_select[0 +: 32], 32'h41);
    chk("core3_addr0_w2", buf_val_2_select[96 +: 32], 32'h12);
    chk("bank1_1_held", buf_val_1_select[32 +: 32], 32'h21);

    // Staggered release with core 2 re-raising early.
    buf_flag_in = 4'b1110; tick();
    chk("ready_hold_a", {31'b0, all_buf_flags}, 32'h1);
    buf_flag_in = 4'b1010; tick();
    chk("ready_hold_b", {31'b0, all_buf_flags}, 32'h1);
    buf_flag_in = 4'b1110; buf_val_1_in[64 +: 32] = 32'h99; tick();
    chk("ready_hold_c", {31'b0, all_buf_flags}, 32'h1);
    buf_flag_in = 4'b0100; tick();
    chk("ready_hold_d", {31'b0, all_buf_flags}, 32'h1);
    buf_flag_in = 4'b0000; tick();
    chk("released_afb", {31'b0, all_buf_flags}, 32'h0);
    chk("released_epoch", {24'b0, epoch}, 32'h1);
    buf_val_1_addr[10 +: 5] = 5'd2;
    #1;
    chk("core2_stale", buf_val_1_select[64 +: 32], 32'h31);
    buf_flag_in = 4'b0100; buf_val_1_in[64 +: 32] = 32'h77; tick();
    chk("core2_recapture", buf_val_1_select[64 +: 32], 32'h77);
    buf_flag_in = 4'b0000; tick();

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      buf_flag_in = ($urandom_range(0, 3) == 0) ? 4'b0 : 4'($urandom);
      for (int i = 0; i < NC; i++) begin
        buf_val_1_in[i*32 +: 32] = $urandom;
        buf_val_2_in[i*32 +: 32] = $urandom;
        buf_val_1_addr[i*5 +: 5] = 5'($urandom_range(0, 7));
        buf_val_2_addr[i*5 +: 5] = 5'($urandom_range(0, 7));
      end
      tick();
    end

    // Reset mid-barrier with three of four cores captured.
    buf_flag_in = 4'b0000;
    Reset = 1'b0; tick();
    Reset = 1'b1;
    buf_flag_in = 4'b0111; tick();
    chk("three_captured_afb", {31'b0, all_buf_flags}, 32'h0);
    Reset = 1'b0;
    #1;
    chk("midreset_afb", {31'b0, all_buf_flags}, 32'h0);
    chk("midreset_epoch", {24'b0, epoch}, 32'h0);
    for (int a = 0; a < NC; a++) begin
      buf_val_1_addr[0 +: 5] = 5'(a);
      buf_val_2_addr[0 +: 5] = 5'(a);
      #1;
      chk("midreset_sel1", buf_val_1_select[0 +: 32], 32'h0);
      chk("midreset_sel2", buf_val_2_select[0 +: 32], 32'h0);
    end
    tick();
    Reset = 1'b1;
    buf_flag_in = 4'b0111; tick();
    chk("need_all_four", {31'b0, all_buf_flags}, 32'h0);
    buf_flag_in = 4'b1111; tick();
    chk("all_four_afb", {31'b0, all_buf_flags}, 32'h1);
    buf_flag_in = 4'b0000; tick();
    chk("post_reset_epoch", {24'b0, epoch}, 32'h1);

    // Out-of-range read and epoch wrap.
    buf_val_1_addr[5 +: 5] = 5'd7;
    buf_val_2_addr[5 +: 5] = 5'd7;
    #1;
    chk("addr7_w1", buf_val_1_select[32 +: 32], 32'h0);
    chk("addr7_w2", buf_val_2_select[32 +: 32], 32'h0);
    for (int b = 0; b < 255; b++) begin
      buf_flag_in = 4'b1111; tick();
      buf_flag_in = 4'b0000; tick();
    end
    chk("epoch_wrap", {24'b0, epoch}, 32'h0);
    chk("wrap_afb", {31'b0, all_buf_flags}, 32'h0);

    tick();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
